axi4_stream_frag_hdr_ins: RTL and testbench
===========================================

AXI4_STREAM_FRAG_HDR_INS -- requirements
Module: axi4_stream_frag_hdr_ins

Interface
REQ-001 Parameter TDATA_WIDTH, default 64, tdata width in bits; SHALL be a multiple of 8 and at least 32.
REQ-002 Parameter TID_WIDTH / TDEST_WIDTH / TUSER_WIDTH, default 1 each, sideband widths.
REQ-003 Parameter MAX_FRAG_SIZE, default 2048, largest fragment in bytes; SHALL be at most 65535 and a multiple of TDATA_WIDTH/8.
REQ-004 clk_i  input  1  clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 pkt_i  axi4_stream_if.slave  parameterised  incoming fragments, tlast marks fragment end (fragmenter output).
REQ-007 pkt_o  axi4_stream_if.master  parameterised  header word followed by the fragment's payload words.
REQ-008 oversize_o  output  1  one-cycle pulse when an input fragment exceeds DEPTH words.

Function
REQ-009 TDATA_WIDTH_B = TDATA_WIDTH/8; DEPTH = MAX_FRAG_SIZE/TDATA_WIDTH_B words of store-and-forward buffer.
REQ-010 FSM states RX, HDR, TX; reset state RX.
REQ-011 RX: pkt_i.tready = 1 and pkt_o.tvalid = 0; each handshake writes tdata/tstrb/tkeep to buffer address wr_cnt; wr_cnt increments.
REQ-012 RX byte count adds popcount(tkeep) per stored word; width 16 bits; no wrap within one fragment.
REQ-013 tid/tdest/tuser SHALL be captured from the first word of a fragment; later words' sideband is ignored.
REQ-014 Words beyond DEPTH SHALL be accepted and discarded (not counted), oversize_o pulses once per fragment, and the last stored word carries tlast on output.
REQ-015 Handshake with tlast in RX -> HDR next cycle; pkt_i.tready = 0 from the cycle after that handshake until return to RX.
REQ-016 HDR: pkt_o.tvalid = 1; tdata[15:0] = byte count, tdata[31:16] = seq_num, other bits 0; tkeep = tstrb = all ones; tlast = 0.
REQ-017 Header tvalid SHALL assert the cycle after the input tlast handshake (latency 1).
REQ-018 HDR handshake -> TX; payload words replay in write order with original tkeep/tstrb; tlast on word wr_cnt-1 only.
REQ-019 TX throughput SHALL be one word per clock while pkt_o.tready is held high; no bubble between header and first payload word.
REQ-020 Output words SHALL hold tdata/tkeep/tstrb/tlast/sideband stable while tvalid=1 and tready=0.
REQ-021 tid/tdest/tuser captured per REQ-013 SHALL be driven on header and all payload words.
REQ-022 Final payload handshake -> RX; seq_num increments (16-bit, wraps 0xFFFF->0x0000); wr_cnt and byte count clear.
REQ-023 A single-word fragment (tlast on first word) SHALL produce header plus one payload word with tlast.
REQ-024 Input word with tkeep = 0 SHALL be stored and replayed, adding 0 to byte count.

Reset
REQ-025 On rst_i: state RX, pkt_o.tvalid = 0, pkt_i.tready = 0 while asserted then 1, oversize_o = 0, seq_num = 0, wr_cnt = 0, byte count = 0.
REQ-026 Reset mid-fragment (any state) SHALL discard buffered data; first fragment after release gets seq_num 0.
REQ-027 Buffer RAM contents need not be reset.

Structure
REQ-028 Header field offsets (length 15:0, seq 31:16) and the FSM state enum SHALL live in the shared axi4_stream package.
REQ-029 Buffer SHALL be one sub-module axi4_stream_frag_ram: simple dual-port, one write port, one read port, read latency 1, width TDATA_WIDTH + 2*TDATA_WIDTH_B.
REQ-030 Read-ahead (prefetch register) SHALL reside in axi4_stream_frag_hdr_ins to meet REQ-019 and REQ-020.

Verification
REQ-031 TDATA_WIDTH=64: 3 words tkeep 0xFF,0xFF,0x0F, tready=1 -> header tdata[31:0]=0x0000_0014, then 3 words, tlast on third, total 4 output cycles.
REQ-032 Two back-to-back fragments -> seq fields 0x0000 then 0x0001; pkt_i.tready low throughout each HDR/TX.
REQ-033 Random pkt_o.tready (50%) on 8-word fragment -> payload bit-exact, stable while stalled, tlast only on word 8.
REQ-034 MAX_FRAG_SIZE=64 (DEPTH 8), 10-word fragment -> oversize_o single pulse, length 64, 8 payload words, tlast on 8th.
REQ-035 rst_i asserted during TX of word 2 of 5 -> tvalid 0 immediately; next fragment header seq 0x0000.
REQ-036 Seq preloaded near wrap via 65536 one-word fragments (or force) -> 0xFFFF followed by 0x0000.

Source files
------------

// File: rtl/axi4_stream_frag_hdr_ins_pkg.sv
// Shared definitions for the fragment header inserter.
//   - header word field positions (length and sequence number)
//   - FSM state encoding used by axi4_stream_frag_hdr_ins
package axi4_stream_frag_hdr_ins_pkg;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_MSB = 15;
    localparam int HDR_SEQ_LSB = 16;
    localparam int HDR_SEQ_MSB = 31;

    typedef enum logic [1:0] {
        ST_RX  = 2'd0,
        ST_HDR = 2'd1,
        ST_TX  = 2'd2
    } frag_state_e;

endpackage

// File: rtl/axi4_stream_frag_hdr_ins_if.sv
// AXI4-Stream bundle used on both sides of the header inserter.
//   master modport : drives tvalid/tdata/tstrb/tkeep/tlast/tid/tdest/tuser, samples tready
//   slave  modport : samples the payload signals, drives tready
interface axi4_stream_frag_hdr_ins_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/axi4_stream_frag_ram.sv
// Simple dual-port fragment buffer: one write port, one registered read port.
//   clk_i   : clock
//   wr_en   : write strobe, wr_addr/wr_data written on the rising edge
//   rd_en   : read strobe, rd_data updates one cycle later and holds otherwise
//   rd_addr : read address
// Contents are not reset.
module axi4_stream_frag_ram #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk_i,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi4_stream_frag_hdr_ins.sv
// Store-and-forward fragment header inserter.
// A whole fragment is buffered, then emitted as one header word
// (byte count, sequence number) followed by the buffered payload words.
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   pkt_i      : incoming fragments, tlast marks fragment end
//   pkt_o      : header word then payload words
//   oversize_o : one-cycle pulse when a fragment has more words than the buffer
//
// state | meaning
// RX    | accepting fragment words into the buffer
// HDR   | presenting the header word
// TX    | replaying buffered payload words
module axi4_stream_frag_hdr_ins
    import axi4_stream_frag_hdr_ins_pkg::*;
#(
    parameter int TDATA_WIDTH   = 64,
    parameter int TID_WIDTH     = 1,
    parameter int TDEST_WIDTH   = 1,
    parameter int TUSER_WIDTH   = 1,
    parameter int MAX_FRAG_SIZE = 2048
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    axi4_stream_frag_hdr_ins_if.slave  pkt_i,
    axi4_stream_frag_hdr_ins_if.master pkt_o,
    output logic                      oversize_o
);

    localparam int TDATA_WIDTH_B = TDATA_WIDTH / 8;
    localparam int DEPTH         = MAX_FRAG_SIZE / TDATA_WIDTH_B;
    localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW            = $clog2(DEPTH + 1);
    localparam int KW            = $clog2(TDATA_WIDTH_B + 1);
    localparam int RAM_W         = TDATA_WIDTH + 2 * TDATA_WIDTH_B;

    frag_state_e            state_q, state_d;
    logic [CW-1:0]          wr_cnt_q;
    logic [CW-1:0]          rd_idx_q;
    logic [15:0]            byte_cnt_q;
    logic [15:0]            seq_num;
    logic [TID_WIDTH-1:0]   tid_q;
    logic [TDEST_WIDTH-1:0] tdest_q;
    logic [TUSER_WIDTH-1:0] tuser_q;
    logic                   ovf_seen_q;

    logic                   rx_ready;
    logic                   in_hs;
    logic                   out_hs;
    logic                   store;
    logic                   tx_last;
    logic [KW-1:0]          keep_cnt;
    logic                   rd_en;
    logic [AW-1:0]          rd_addr;
    logic [RAM_W-1:0]       wr_data;
    logic [RAM_W-1:0]       rd_data;

    assign rx_ready     = (state_q == ST_RX) && !rst_i;
    assign pkt_i.tready = rx_ready;
    assign in_hs        = pkt_i.tvalid && rx_ready;
    assign out_hs       = pkt_o.tvalid && pkt_o.tready;
    // Words past the buffer capacity are accepted but dropped.
    assign store        = in_hs && (wr_cnt_q < CW'(DEPTH));
    assign tx_last      = (rd_idx_q == wr_cnt_q - CW'(1));
    assign wr_data      = {pkt_i.tstrb, pkt_i.tkeep, pkt_i.tdata};

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < TDATA_WIDTH_B; i++) begin
            keep_cnt = keep_cnt + KW'(pkt_i.tkeep[i]);
        end
    end

    // Read-ahead: the word for the next beat is requested one cycle early
    // (word 0 during HDR, word k+1 on the handshake of word k). The RAM
    // read register only loads on rd_en, so it doubles as the holding
    // register while the sink stalls.
    always_comb begin
        state_d      = state_q;
        pkt_o.tvalid = 1'b0;
        pkt_o.tdata  = '0;
        pkt_o.tkeep  = '0;
        pkt_o.tstrb  = '0;
        pkt_o.tlast  = 1'b0;
        pkt_o.tid    = tid_q;
        pkt_o.tdest  = tdest_q;
        pkt_o.tuser  = tuser_q;
        rd_en        = 1'b0;
        rd_addr      = '0;
        case (state_q)
            ST_RX: begin
                if (in_hs && pkt_i.tlast) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                pkt_o.tvalid                          = 1'b1;
                pkt_o.tdata[HDR_LEN_MSB:HDR_LEN_LSB] = byte_cnt_q;
                pkt_o.tdata[HDR_SEQ_MSB:HDR_SEQ_LSB] = seq_num;
                pkt_o.tkeep                           = '1;
                pkt_o.tstrb                           = '1;
                rd_en                                 = 1'b1;
                if (pkt_o.tready) begin
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                pkt_o.tvalid = 1'b1;
                pkt_o.tdata  = rd_data[TDATA_WIDTH-1:0];
                pkt_o.tkeep  = rd_data[TDATA_WIDTH +: TDATA_WIDTH_B];
                pkt_o.tstrb  = rd_data[TDATA_WIDTH + TDATA_WIDTH_B +: TDATA_WIDTH_B];
                pkt_o.tlast  = tx_last;
                if (pkt_o.tready) begin
                    rd_en   = 1'b1;
                    rd_addr = AW'(rd_idx_q + CW'(1));
                    if (tx_last) begin
                        state_d = ST_RX;
                    end
                end
            end
            default: state_d = ST_RX;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RX;
            wr_cnt_q   <= '0;
            rd_idx_q   <= '0;
            byte_cnt_q <= '0;
            seq_num    <= '0;
            tid_q      <= '0;
            tdest_q    <= '0;
            tuser_q    <= '0;
            ovf_seen_q <= 1'b0;
            oversize_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            oversize_o <= 1'b0;
            if (in_hs) begin
                if (wr_cnt_q == '0) begin
                    tid_q   <= pkt_i.tid;
                    tdest_q <= pkt_i.tdest;
                    tuser_q <= pkt_i.tuser;
                end
                if (store) begin
                    wr_cnt_q   <= wr_cnt_q + CW'(1);
                    byte_cnt_q <= byte_cnt_q + 16'(keep_cnt);
                end else if (!ovf_seen_q) begin
                    oversize_o <= 1'b1;
                    ovf_seen_q <= 1'b1;
                end
                if (pkt_i.tlast) begin
                    ovf_seen_q <= 1'b0;
                end
            end
            if (state_q == ST_RX) begin
                rd_idx_q <= '0;
            end
            if (state_q == ST_TX && out_hs) begin
                rd_idx_q <= rd_idx_q + CW'(1);
                if (tx_last) begin
                    seq_num    <= seq_num + 16'd1;
                    wr_cnt_q   <= '0;
                    byte_cnt_q <= '0;
                end
            end
        end
    end

    axi4_stream_frag_ram #(
        .WIDTH (RAM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (store),
        .wr_addr (AW'(wr_cnt_q)),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_axi4_stream_frag_hdr_ins.sv
// Scoreboard bench for axi4_stream_frag_hdr_ins (64-bit data, 8-word buffer).
module tb_axi4_stream_frag_hdr_ins;

    localparam int DW       = 64;
    localparam int KB       = DW / 8;
    localparam int SW       = 4;
    localparam int MAX_FRAG = 64;
    localparam int DEPTH    = MAX_FRAG / KB;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KB-1:0] keep;
        logic [KB-1:0] strb;
        logic          last;
        logic [SW-1:0] id;
        logic [SW-1:0] dest;
        logic [SW-1:0] user;
    } beat_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic oversize;

    always #5 clk = ~clk;

    axi4_stream_frag_hdr_ins_if #(.TDATA_WIDTH(DW), .TID_WIDTH(SW), .TDEST_WIDTH(SW), .TUSER_WIDTH(SW)) in_if ();
    axi4_stream_frag_hdr_ins_if #(.TDATA_WIDTH(DW), .TID_WIDTH(SW), .TDEST_WIDTH(SW), .TUSER_WIDTH(SW)) out_if ();

    axi4_stream_frag_hdr_ins #(
        .TDATA_WIDTH   (DW),
        .TID_WIDTH     (SW),
        .TDEST_WIDTH   (SW),
        .TUSER_WIDTH   (SW),
        .MAX_FRAG_SIZE (MAX_FRAG)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .pkt_i      (in_if.slave),
        .pkt_o      (out_if.master),
        .oversize_o (oversize)
    );

    beat_t       exp_q[$];
    logic [7:0]  keep_plan[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_ovf = 0;
    int          got_ovf = 0;
    logic [15:0] model_seq = 16'd0;
    int          ready_mode = 0;
    logic        manual_ready = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic beat_t cur_out();
        beat_t b;
        b.data = out_if.tdata;
        b.keep = out_if.tkeep;
        b.strb = out_if.tstrb;
        b.last = out_if.tlast;
        b.id   = out_if.tid;
        b.dest = out_if.tdest;
        b.user = out_if.tuser;
        return b;
    endfunction

    // Sink ready: 0 = always ready, 1 = random 50%, otherwise manual_ready.
    initial begin
        out_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 0)      out_if.tready = 1'b1;
            else if (ready_mode == 1) out_if.tready = 1'($urandom_range(0, 1));
            else                      out_if.tready = manual_ready;
        end
    end

    // Monitor: samples mid-cycle the values that the next rising edge will transfer.
    beat_t mon_b, mon_prev;
    logic  stall_prev = 1'b0, nonlast_prev = 1'b0, tlast_in_prev = 1'b0, ovf_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_i) begin
            stall_prev    = 1'b0;
            nonlast_prev  = 1'b0;
            tlast_in_prev = 1'b0;
            ovf_prev      = 1'b0;
        end else begin
            mon_b = cur_out();
            if (tlast_in_prev) chk("hdr_latency", out_if.tvalid, 1'b1);
            if (nonlast_prev)  chk("no_bubble", out_if.tvalid, 1'b1);
            if (stall_prev)    chk("hold_stable", mon_b, mon_prev);
            if (out_if.tvalid) chk("in_ready_busy", in_if.tready, 1'b0);
            if (oversize) begin
                got_ovf++;
                if (ovf_prev) chk("oversize_width", 2, 1);
            end
            if (out_if.tvalid && out_if.tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", mon_b, '0);
                end else begin
                    chk("beat", mon_b, exp_q.pop_front());
                end
            end
            stall_prev    = out_if.tvalid && !out_if.tready;
            nonlast_prev  = out_if.tvalid && out_if.tready && !out_if.tlast;
            tlast_in_prev = in_if.tvalid && in_if.tready && in_if.tlast;
            ovf_prev      = oversize;
            mon_prev      = mon_b;
        end
    end

    // Builds a fragment, pushes its expected output (header + stored words),
    // then drives it. max_push < 0 pushes everything.
    task automatic send_frag(input int n, input int max_push, input bit gaps);
        beat_t       w[$];
        beat_t       h;
        beat_t       e;
        int          stored;
        int          pushed;
        logic [15:0] len;
        logic        hs;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = {$urandom(), $urandom()};
            if (keep_plan.size() > 0)         b.keep = keep_plan.pop_front();
            else if ($urandom_range(0, 7) == 0) b.keep = '0;
            else                               b.keep = 8'($urandom());
            b.strb = b.keep & 8'($urandom());
            b.last = (i == n - 1);
            b.id   = 4'($urandom());
            b.dest = 4'($urandom());
            b.user = 4'($urandom());
            w.push_back(b);
        end
        stored = (n > DEPTH) ? DEPTH : n;
        len = 16'd0;
        for (int i = 0; i < stored; i++) len = len + 16'($countones(w[i].keep));
        h.data = {32'd0, model_seq, len};
        h.keep = '1;
        h.strb = '1;
        h.last = 1'b0;
        h.id   = w[0].id;
        h.dest = w[0].dest;
        h.user = w[0].user;
        pushed = 0;
        if (max_push < 0 || pushed < max_push) begin
            exp_q.push_back(h);
            pushed++;
        end
        for (int i = 0; i < stored; i++) begin
            e      = w[i];
            e.last = (i == stored - 1);
            e.id   = w[0].id;
            e.dest = w[0].dest;
            e.user = w[0].user;
            if (max_push < 0 || pushed < max_push) begin
                exp_q.push_back(e);
                pushed++;
            end
        end
        model_seq = model_seq + 16'd1;
        if (n > DEPTH) exp_ovf++;

        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_if.tvalid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_if.tvalid = 1'b1;
            in_if.tdata  = w[i].data;
            in_if.tkeep  = w[i].keep;
            in_if.tstrb  = w[i].strb;
            in_if.tlast  = w[i].last;
            in_if.tid    = w[i].id;
            in_if.tdest  = w[i].dest;
            in_if.tuser  = w[i].user;
            hs = 1'b0;
            for (int c = 0; c < 3000 && !hs; c++) begin
                @(negedge clk);
                hs = in_if.tready;
                @(posedge clk);
                #1;
            end
            if (!hs) begin
                n_vec++;
                n_err++;
                $display("FAIL in_accept_timeout got=stalled want=accepted");
                break;
            end
        end
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while ((exp_q.size() != 0 || out_if.tvalid) && c < 5000);
        @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tkeep  = '0;
        in_if.tstrb  = '0;
        in_if.tlast  = 1'b0;
        in_if.tid    = '0;
        in_if.tdest  = '0;
        in_if.tuser  = '0;

        #12;
        chk("rst_out_tvalid", out_if.tvalid, 1'b0);
        chk("rst_in_tready", in_if.tready, 1'b0);
        chk("rst_oversize", oversize, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_in_tready", in_if.tready, 1'b1);
        @(posedge clk);
        #1;

        // 3 words 0xFF,0xFF,0x0F -> length 20, seq 0
        ready_mode = 0;
        keep_plan = {8'hFF, 8'hFF, 8'h0F};
        send_frag(3, -1, 1'b0);
        wait_idle();

        // back-to-back fragments
        send_frag(4, -1, 1'b0);
        send_frag(2, -1, 1'b0);
        wait_idle();

        // random sink stalls on a full 8-word fragment
        ready_mode = 1;
        send_frag(8, -1, 1'b0);
        wait_idle();

        // oversize fragments
        ready_mode = 0;
        send_frag(10, -1, 1'b0);
        ready_mode = 1;
        send_frag(12, -1, 1'b1);
        wait_idle();

        // single-word and empty-keep words
        ready_mode = 0;
        keep_plan = {8'h00};
        send_frag(1, -1, 1'b0);
        keep_plan = {8'h00, 8'hFF};
        send_frag(2, -1, 1'b0);
        wait_idle();

        // reset while word 2 of 5 is on the output
        ready_mode   = 2;
        manual_ready = 1'b0;
        send_frag(5, 2, 1'b0);
        manual_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i        = 1'b1;
        manual_ready = 1'b0;
        #1;
        chk("midtx_rst_tvalid", out_if.tvalid, 1'b0);
        chk("midtx_rst_in_tready", in_if.tready, 1'b0);
        chk("midtx_rst_flush", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_i      = 1'b0;
        model_seq  = 16'd0;
        ready_mode = 0;
        send_frag(3, -1, 1'b1);
        wait_idle();

        // sequence number wrap
        force dut.seq_num = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.seq_num;
        model_seq = 16'hFFFF;
        send_frag(1, -1, 1'b0);
        send_frag(1, -1, 1'b0);
        wait_idle();

        // random traffic
        for (int f = 0; f < 40; f++) begin
            ready_mode = $urandom_range(0, 1);
            send_frag($urandom_range(1, 10), -1, 1'b1);
        end
        wait_idle();

        chk("oversize_count", got_ovf, exp_ovf);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
